// File: rtl/stmm_result_writer.sv
// StMM result write-back: takes one N*Q-bit result row per handshake and streams it
// to SDRAM as SDRAM_W-bit beats at contiguous word addresses, pulsing done per job.
module stmm_result_writer #(
  parameter int N       = 176,
  parameter int Q       = 8,
  parameter int SDRAM_W = 128,
  parameter int ADDR_W  = 25,
  parameter int ROWS_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ROWS_W-1:0]    num_rows,
  input  logic                 y_valid,
  input  logic [N*Q-1:0]       y_data,
  output logic                 y_ready,
  output logic                 wr_valid,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [SDRAM_W-1:0]   wr_data,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int RW     = N * Q;
  localparam int BEATS  = (RW + SDRAM_W - 1) / SDRAM_W;
  localparam int PAD_W  = BEATS * SDRAM_W;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ROW,
    S_SEND,
    S_DONE
  } state_t;

  state_t              state, state_next;
  logic [BEAT_W-1:0]   beat;
  logic [ROWS_W-1:0]   row;
  logic [ROWS_W-1:0]   num_rows_q;
  logic [ADDR_W-1:0]   cur_addr;
  logic [PAD_W-1:0]    row_buf;
  logic                last_beat;

  assign last_beat = (beat == BEAT_W'(BEATS - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      beat       <= '0;
      row        <= '0;
      num_rows_q <= '0;
      cur_addr   <= '0;
      // NOTE: the row buffer is a plain register, not a RAM, so it can and does take
      // the async reset; this keeps wr_data at zero straight out of reset.
      row_buf    <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr   <= base_addr;
            num_rows_q <= num_rows;
            row        <= '0;
          end
        end
        S_WAIT_ROW: begin
          if (y_valid) begin
            // Zero-extension pads the top of the last beat when RW is not beat-aligned.
            row_buf <= PAD_W'(y_data);
            beat    <= '0;
          end
        end
        S_SEND: begin
          if (wr_ready) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            beat     <= last_beat ? '0 : beat + BEAT_W'(1);
            if (last_beat) row <= row + ROWS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    y_ready    = 1'b0;
    wr_valid   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = (num_rows == '0) ? S_DONE : S_WAIT_ROW;
      end
      S_WAIT_ROW: begin
        y_ready = 1'b1;
        if (y_valid) state_next = S_SEND;
      end
      S_SEND: begin
        wr_valid = 1'b1;
        if (wr_ready && last_beat)
          state_next = ((row + ROWS_W'(1)) == num_rows_q) ? S_DONE : S_WAIT_ROW;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign wr_addr = cur_addr;
  assign wr_data = row_buf[int'(beat) * SDRAM_W +: SDRAM_W];

endmodule

// File: tb/tb_stmm_result_writer.sv
// Randomised scoreboard bench for stmm_result_writer: jobs push expected beats into a
// queue built from whole-row arithmetic; a monitor pops and compares on each write beat.
module tb_stmm_result_writer;

  localparam int N     = 176;
  localparam int Q     = 8;
  localparam int SW    = 128;
  localparam int AW    = 25;
  localparam int RWD   = 8;
  localparam int RW    = N * Q;
  localparam int BEATS = (RW + SW - 1) / SW;
  localparam int PW    = BEATS * SW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [AW-1:0]  base_addr;
  logic [RWD-1:0] num_rows;
  logic           y_valid;
  logic [RW-1:0]  y_data;
  logic           y_ready;
  logic           wr_valid;
  logic [AW-1:0]  wr_addr;
  logic [SW-1:0]  wr_data;
  logic           wr_ready;
  logic           busy;
  logic           done;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    beats_seen = 0;
  bit    rdy_mode = 1'b1;
  bit    abort_rows = 1'b0;

  stmm_result_writer #(.N(N), .Q(Q), .SDRAM_W(SW), .ADDR_W(AW), .ROWS_W(RWD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .y_valid(y_valid), .y_data(y_data), .y_ready(y_ready), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write-side back-pressure: always ready, or a fair coin every cycle.
  initial begin
    wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      wr_ready = rdy_mode ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares every accepted beat and checks hold-while-stalled behaviour.
  initial begin
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [SW-1:0] prev_data;
    beat_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else if (wr_valid) begin
        check("y_ready_low_in_send", SW'(y_ready), '0);
        if (prev_stall) begin
          check("stall_addr_stable", SW'(wr_addr), SW'(prev_addr));
          check("stall_data_stable", wr_data, prev_data);
        end
        if (wr_ready) begin
          check("beat_expected", SW'(exp_q.size() > 0), SW'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", SW'(wr_addr), SW'(e.addr));
            check("wr_data", wr_data, e.data);
          end
          beats_seen++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = 1'b1;
          prev_addr  = wr_addr;
          prev_data  = wr_data;
        end
      end else begin
        if (prev_stall) check("wr_valid_held", SW'(wr_valid), SW'(1));
        prev_stall = 1'b0;
      end
    end
  end

  function automatic logic [RW-1:0] make_row(input bit pattern);
    logic [RW-1:0] d = '0;
    if (pattern) begin
      for (int i = 0; i < N; i++) d[i*Q +: Q] = Q'(i);
    end else begin
      for (int k = 0; k < RW; k += 32) d = {d[RW-33:0], 32'($urandom())};
    end
    return d;
  endfunction

  // Reference: row r beat b lands at base + r*BEATS + b (mod 2^AW) and carries the
  // b-th SW-bit slice of the zero-extended row.
  task automatic push_expected(input logic [AW-1:0] base, input int r, input logic [RW-1:0] d);
    logic [PW-1:0] padded;
    beat_t         e;
    padded = PW'(d);
    for (int b = 0; b < BEATS; b++) begin
      e.addr = AW'(int'(base) + r * BEATS + b);
      e.data = SW'(padded >> (b * SW));
      exp_q.push_back(e);
    end
  endtask

  task automatic send_row(input logic [RW-1:0] d, output bit ok);
    ok      = 1'b0;
    y_data  = d;
    y_valid = 1'b1;
    for (int c = 0; c < 3000 && !abort_rows; c++) begin
      @(negedge clk);
      if (y_ready && rst_n) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
    end
    y_valid = 1'b0;
  endtask

  task automatic pulse_start(input logic [AW-1:0] base, input int nr, output int start_cyc);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    num_rows  = RWD'(nr);
    @(posedge clk); #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input int nr, input bit pattern,
                         input bit rnd_rdy, input bit inject);
    logic [RW-1:0] rows[$];
    int            start_cyc;
    int            lat = -1;
    int            limit;
    bit            got_done = 1'b0;
    for (int r = 0; r < nr; r++) begin
      rows.push_back(make_row(pattern));
      push_expected(base, r, rows[r]);
    end
    rdy_mode = !rnd_rdy;
    limit = nr * (BEATS + 1) * 12 + 40;
    pulse_start(base, nr, start_cyc);
    fork
      begin
        bit ok;
        for (int r = 0; r < nr; r++) begin
          send_row(rows[r], ok);
          check("row_accepted", SW'(ok), SW'(1));
        end
      end
      begin
        for (int c = 0; c < limit; c++) begin
          @(negedge clk);
          if (nr == 0) check("empty_job_quiet", SW'({y_ready, wr_valid}), '0);
          if (done) begin
            got_done = 1'b1;
            lat = cyc - start_cyc;
            break;
          end
        end
      end
      begin
        if (inject) begin
          for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wr_valid) break;
          end
          @(posedge clk); #1;
          start = 1'b1; base_addr = '0; num_rows = RWD'(5);
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    join
    check("done_seen", SW'(got_done), SW'(1));
    check("latency_min", SW'(lat >= nr * (BEATS + 1)), SW'(1));
    if (!rnd_rdy) check("latency_max", SW'(lat <= nr * (BEATS + 1) + 2), SW'(1));
    check("all_beats_written", SW'(exp_q.size()), '0);
    @(negedge clk);
    check("done_one_cycle", SW'({done, busy}), '0);
  endtask

  initial begin
    int s_cyc;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0;
    y_valid = 1'b0; y_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", SW'({y_ready, wr_valid, busy, done}), '0);
    check("reset_wr_addr", SW'(wr_addr), '0);
    check("reset_wr_data", wr_data, '0);
    rst_n = 1'b1;

    // T1: incrementing-element row, always ready
    run_job(AW'('h100), 1, 1'b1, 1'b0, 1'b0);
    // T2: three random rows under random back-pressure
    run_job(AW'($urandom()), 3, 1'b0, 1'b1, 1'b0);
    // T3: empty job
    run_job(AW'('h55), 0, 1'b0, 1'b0, 1'b0);
    // T4: address wrap
    run_job(AW'((1 << AW) - 5), 1, 1'b0, 1'b0, 1'b0);
    // T5: start during SEND ignored; next row held on y_valid while draining
    run_job(AW'('h3000), 2, 1'b0, 1'b1, 1'b1);

    // T6: reset mid beat 6 of row 2, then a clean job
    begin
      logic [RW-1:0] rows[$];
      int            base_seen;
      for (int r = 0; r < 3; r++) begin
        rows.push_back(make_row(1'b0));
        push_expected(AW'('h1F00), r, rows[r]);
      end
      rdy_mode = 1'b1;
      base_seen = beats_seen;
      pulse_start(AW'('h1F00), 3, s_cyc);
      fork
        begin
          bit ok;
          for (int r = 0; r < 3 && !abort_rows; r++) send_row(rows[r], ok);
        end
        begin
          for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (beats_seen >= base_seen + BEATS + 5) break;
          end
          @(posedge clk); #3;
          check("mid_beat_valid", SW'(wr_valid), SW'(1));
          rst_n = 1'b0;
          abort_rows = 1'b1;
          #1;
          check("async_reset_outputs", SW'({y_ready, wr_valid, busy, done}), '0);
          check("async_reset_addr", SW'(wr_addr), '0);
          check("async_reset_data", wr_data, '0);
          exp_q.delete();
        end
      join
      repeat (2) @(negedge clk);
      check("no_done_after_abort", SW'(done), '0);
      rst_n = 1'b1;
      abort_rows = 1'b0;
      run_job(AW'('h2000), 2, 1'b0, 1'b0, 1'b0);
    end

    // A few extra random jobs
    for (int j = 0; j < 4; j++)
      run_job(AW'($urandom()), $urandom_range(1, 4), 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
